spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable SPI flash responder: the device end of the SoC's flash SPI link (sclk/cs_n/mosi out, miso in). It decodes mode-0 flash commands from the SoC master and streams bytes from an external byte-wide memory port back on MISO. It sits in simulation and FPGA builds in place of a physical flash part, so boot code can be fetched without external hardware. SPI signals are oversampled on the system clock; no logic is clocked by SCLK.

## Interface
- ADDR_W, 16: implemented address bits; upper command-address bits ignored
- JEDEC_ID, 24'hEF4016: bytes returned by 0x9F, MSB byte first
- clk  in  1  system clock; SCLK half-period ≥ 4 clk cycles
- reset  in  1  asynchronous, active-high
- i_flash_sclk  in  1  SPI clock from master, asynchronous
- i_flash_cs_n  in  1  chip select, active-low, asynchronous
- i_flash_mosi  in  1  master data
- o_flash_miso  out  1  responder data
- o_mem_rd  out  1  one-cycle read strobe
- o_mem_addr  out  ADDR_W  byte address
- i_mem_rdata  in  8  byte, valid exactly one cycle after o_mem_rd

## Operation
- Inputs pass through 2-flop synchronizers; SCLK rise/fall and CS_n rise/fall are detected from the synchronized values.
- Mode 0: shift MOSI in on SCLK rise, MSB first; update MISO on SCLK fall.
- States: IDLE, CMD, ADDR, DUMMY, DATA, ID, IGNORE.
- IDLE -> CMD on CS_n fall. Clear the bit counter (3 bits) and byte counter.
- CMD: after 8 bits, decode the opcode.
  - 0x03 -> ADDR.
  - 0x9F -> ID.
  - Any other opcode -> IGNORE.
- ADDR: collect 24 bits and keep the low ADDR_W bits. On the 24th rise, pulse o_mem_rd with that address, then -> DATA.
- DATA:
  - Load rdata into the TX shift register the cycle after o_mem_rd.
  - Drive each bit on SCLK fall; the first data MSB appears on the fall after the last address bit.
  - On the cycle the shift register loads, issue the prefetch read at addr+1.
  - Address increments modulo 2^ADDR_W: 0xFFFF wraps to 0x0000.
- ID: shift out JEDEC_ID[23:16], then [15:8], then [7:0]; after that, MISO = 0 until CS_n rises.
- IGNORE: MISO = 0, no memory reads.
- CS_n rise in any state -> IDLE next cycle. MISO = 0, pending shift data is discarded, and o_mem_rd is not pulsed. A read already issued is ignored.
- SCLK edges while CS_n is high are ignored.
- Simultaneous CS_n rise and SCLK edge: the CS_n rise wins.

## Timing
- Reset values: o_flash_miso = 0, o_mem_rd = 0, o_mem_addr = 0, state = IDLE.
- Reset mid-transfer aborts the transfer. The master must restart with CS_n high-then-low.
- Input to internal edge detect: 3 clk cycles.
- MISO changes ≤ 1 clk after the detected SCLK fall, i.e. ≤ 4 clk after the pin fall.
- Memory read completes 2 clk after the 24th address-bit rise. This is before the following SCLK fall, given the half-period ≥ 4 clk.
- o_mem_rd is always a single-cycle pulse; at most one read is outstanding.

## Configuration
- SPI_FLASH_FAST_READ_EN
  - Defined: opcode 0x0B is accepted. ADDR -> DUMMY, which counts 8 SCLK rises (MISO = 0). The read is issued at the end of DUMMY, then -> DATA; the first data MSB is on the fall after the 8th dummy rise.
  - Undefined: 0x0B -> IGNORE.

## Structure
- Package spi_flash_pkg: state enum; opcode constants CMD_READ = 8'h03, CMD_FAST_READ = 8'h0B, CMD_RDID = 8'h9F.
- Sub-module spi_sync_edge: 2-flop synchronizer with registered rise/fall pulses. Instantiated for SCLK and CS_n; MOSI uses the synchronizer only.

## Test plan
- mem[i] = i[7:0]; READ 0x03 addr 0x000010, 3 bytes -> MISO 0x10, 0x11, 0x12; o_mem_addr sequence 0x10, 0x11, 0x12, 0x13 (prefetch).
- 0x9F, 4 bytes -> 0xEF, 0x40, 0x16, 0x00.
- READ addr 0x00FFFF (ADDR_W = 16), 2 bytes -> mem[0xFFFF], then mem[0x0000]; addr 0xAB1234 -> reads from 0x1234.
- Opcode 0xAB, 2 bytes -> MISO held 0, o_mem_rd never asserted.
- CS_n high after 12 address bits, then a full READ addr 0x20 -> correct byte 0x20, no stale data.
- Reset asserted mid-DATA -> MISO 0 within 1 clk; a subsequent READ is correct. Under SPI_FLASH_FAST_READ_EN, 0x0B addr 0x05 + 8 dummy clocks -> 0x05, 0x06.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared state encoding and opcode constants for the SPI flash responder.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin with registered rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            s3   <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash responder: READ / RDID, streaming bytes from a byte-wide memory port.
// Optional fast read (0x0B with 8 dummy clocks) is enabled by SPI_FLASH_FAST_READ_EN.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flash_sclk,
    input  logic              i_flash_cs_n,
    input  logic              i_flash_mosi,
    output logic              o_flash_miso,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_m, mosi_s;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(i_flash_sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(i_flash_cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI lines up with the registered SCLK rise pulse one cycle after its second flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            mosi_m <= i_flash_mosi;
            mosi_s <= mosi_m;
        end
    end

    state_t            state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [6:0]        cmd_sh, cmd_sh_nxt;
    logic [ADDR_W-1:0] addr_sh, addr_sh_nxt;
    logic [7:0]        tx_sr, tx_sr_nxt;
    logic [7:0]        pf_byte, pf_byte_nxt;
    logic              rd_d, rd_d_nxt;
    logic              primed, primed_nxt;
    logic              fast, fast_nxt;
    logic              miso_nxt;
    logic              mem_rd_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            byte_cnt     <= 2'd0;
            cmd_sh       <= 7'd0;
            addr_sh      <= '0;
            tx_sr        <= 8'd0;
            pf_byte      <= 8'd0;
            rd_d         <= 1'b0;
            primed       <= 1'b0;
            fast         <= 1'b0;
            o_flash_miso <= 1'b0;
            o_mem_rd     <= 1'b0;
            o_mem_addr   <= '0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            byte_cnt     <= byte_cnt_nxt;
            cmd_sh       <= cmd_sh_nxt;
            addr_sh      <= addr_sh_nxt;
            tx_sr        <= tx_sr_nxt;
            pf_byte      <= pf_byte_nxt;
            rd_d         <= rd_d_nxt;
            primed       <= primed_nxt;
            fast         <= fast_nxt;
            o_flash_miso <= miso_nxt;
            o_mem_rd     <= mem_rd_nxt;
            o_mem_addr   <= mem_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        cmd_sh_nxt   = cmd_sh;
        addr_sh_nxt  = addr_sh;
        tx_sr_nxt    = tx_sr;
        pf_byte_nxt  = pf_byte;
        rd_d_nxt     = o_mem_rd;
        primed_nxt   = primed;
        fast_nxt     = fast;
        miso_nxt     = o_flash_miso;
        mem_rd_nxt   = 1'b0;
        mem_addr_nxt = o_mem_addr;
        opcode       = {cmd_sh, mosi_s};
        addr_new     = {addr_sh[ADDR_W-2:0], mosi_s};

        // CS_n rise outranks every SCLK edge and drops any read in flight.
        if (cs_rise) begin
            state_nxt  = ST_IDLE;
            miso_nxt   = 1'b0;
            rd_d_nxt   = 1'b0;
            primed_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    miso_nxt = 1'b0;
                    if (cs_fall) begin
                        state_nxt    = ST_CMD;
                        bit_cnt_nxt  = 3'd0;
                        byte_cnt_nxt = 2'd0;
                        fast_nxt     = 1'b0;
                        primed_nxt   = 1'b0;
                    end
                end
                ST_CMD: begin
                    miso_nxt = 1'b0;
                    if (sclk_rise) begin
                        cmd_sh_nxt  = opcode[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt = 3'd0;
                            case (opcode)
                                CMD_READ: state_nxt = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                                CMD_FAST_READ: begin
                                    state_nxt = ST_ADDR;
                                    fast_nxt  = 1'b1;
                                end
`endif
                                CMD_RDID: begin
                                    state_nxt = ST_ID;
                                    tx_sr_nxt = JEDEC_ID[23:16];
                                end
                                default: state_nxt = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    miso_nxt = 1'b0;
                    if (sclk_rise) begin
                        addr_sh_nxt = addr_new;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt_nxt = byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                if (fast) begin
                                    state_nxt = ST_DUMMY;
                                end else begin
                                    state_nxt    = ST_DATA;
                                    mem_rd_nxt   = 1'b1;
                                    mem_addr_nxt = addr_new;
                                end
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    miso_nxt = 1'b0;
                    if (sclk_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt    = ST_DATA;
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = addr_sh;
                        end
                    end
                end
                ST_DATA: begin
                    // First returned byte goes straight to the shifter; later ones wait in pf_byte.
                    if (rd_d) begin
                        if (!primed) begin
                            tx_sr_nxt    = i_mem_rdata;
                            primed_nxt   = 1'b1;
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = ADDR_W'(o_mem_addr + 1'b1);
                        end else begin
                            pf_byte_nxt = i_mem_rdata;
                        end
                    end
                    if (sclk_fall) begin
                        miso_nxt    = tx_sr[7];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_sr_nxt    = pf_byte;
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = ADDR_W'(o_mem_addr + 1'b1);
                        end else begin
                            tx_sr_nxt = {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                ST_ID: begin
                    if (sclk_fall) begin
                        miso_nxt    = tx_sr[7];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt != 2'd3) begin
                                byte_cnt_nxt = byte_cnt + 2'd1;
                            end
                            case (byte_cnt)
                                2'd0:    tx_sr_nxt = JEDEC_ID[15:8];
                                2'd1:    tx_sr_nxt = JEDEC_ID[7:0];
                                default: tx_sr_nxt = 8'd0;
                            endcase
                        end else begin
                            tx_sr_nxt = {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_nxt = 1'b0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    miso_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench: drives SPI frames and compares MISO bytes and memory reads to a byte-level model.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 16;
    localparam logic [23:0] JEDEC  = 24'hEF4016;
    localparam int unsigned HALF   = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'd0;

    logic [7:0]        mem [0:65535];
    logic [15:0]       rd_q [$];
    logic              rd_prev = 1'b0;
    int                dbl_pulse = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(JEDEC)) dut (
        .clk(clk), .reset(reset),
        .i_flash_sclk(sclk), .i_flash_cs_n(cs_n), .i_flash_mosi(mosi),
        .o_flash_miso(miso), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed byte from the read cycle onwards; also logs every read.
    always @(negedge clk) begin
        if (mem_rd) begin
            mem_rdata = mem[mem_addr];
            rd_q.push_back(mem_addr);
        end
        if (mem_rd && rd_prev) dbl_pulse++;
        rd_prev = mem_rd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_clks(HALF);
        r = miso;
        sclk = 1'b1;
        wait_clks(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic end_cs();
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    function automatic bit is_read(input logic [7:0] op);
`ifdef SPI_FLASH_FAST_READ_EN
        return (op == 8'h03) || (op == 8'h0B);
`else
        return op == 8'h03;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] addr, input int k);
        if (is_read(op)) return mem[16'(addr + 24'(k))];
        if (op == 8'h9F) return (k < 3) ? JEDEC[8*(2-k) +: 8] : 8'h00;
        return 8'h00;
    endfunction

    // One complete frame; the master always sends the address (and dummy byte for 0x0B).
    task automatic txn(input logic [7:0] op, input logic [23:0] addr, input int n, input string tag);
        logic [7:0] rx;
        rd_q.delete();
        cs_n = 1'b0;
        spi_byte(op, rx);
        if (op == 8'h03 || op == 8'h0B) begin
            spi_byte(addr[23:16], rx);
            spi_byte(addr[15:8], rx);
            spi_byte(addr[7:0], rx);
            if (op == 8'h0B) spi_byte(8'($urandom), rx);
        end
        for (int k = 0; k < n; k++) begin
            spi_byte(8'($urandom), rx);
            chk($sformatf("%s_byte%0d", tag, k), 32'(rx), 32'(exp_byte(op, addr, k)));
        end
        end_cs();
        chk($sformatf("%s_miso_idle", tag), 32'(miso), 32'd0);
        if (is_read(op)) begin
            chk($sformatf("%s_nreads", tag), 32'((rd_q.size() >= n + 1) && (rd_q.size() <= n + 2)), 32'd1);
            for (int k = 0; k <= n && k < rd_q.size(); k++)
                chk($sformatf("%s_raddr%0d", tag, k), 32'(rd_q[k]), 32'(16'(addr + 24'(k))));
        end else begin
            chk($sformatf("%s_nreads", tag), 32'(rd_q.size()), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rx;
        logic        rb;
        logic [7:0]  op;
        logic [23:0] addr;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

        wait_clks(4);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        wait_clks(4);

        txn(8'h03, 24'h000010, 3, "read10");
        txn(8'h9F, 24'h0, 4, "rdid");
        txn(8'h03, 24'h00FFFF, 2, "wrap");
        txn(8'h03, 24'hAB1234, 2, "hiaddr");
        txn(8'hAB, 24'h0, 2, "ignore");

        // Abort after 12 address bits, then a clean read.
        rd_q.delete();
        cs_n = 1'b0;
        spi_byte(8'h03, rx);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, rb);
        end_cs();
        chk("abort_nreads", 32'(rd_q.size()), 32'd0);
        txn(8'h03, 24'h000020, 2, "after_abort");

        // Reset in the middle of a data byte of 0xFF.
        cs_n = 1'b0;
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, rb);
        wait_clks(5);
        chk("mid_data_miso", 32'(miso), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_mem_rd", 32'(mem_rd), 32'd0);
        cs_n = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(6);
        txn(8'h03, 24'h000030, 2, "after_reset");

`ifdef SPI_FLASH_FAST_READ_EN
        txn(8'h0B, 24'h000005, 2, "fast");
`else
        txn(8'h0B, 24'h000005, 2, "fast_off");
`endif

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: op = 8'h9F;
                1: op = 8'h0B;
                2: op = 8'($urandom);
                default: op = 8'h03;
            endcase
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
            txn(op, addr, int'($urandom_range(1, 4)), $sformatf("rnd%0d", t));
        end

        chk("rd_pulse_width", 32'(dbl_pulse), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
